pic_inta_initiator: RTL and testbench

// - CPU-side end of the PIC acknowledge protocol. It sees INT from the interrupt block and drives the two-pulse INTA_N sequence.
// - Captures the vector byte that the PIC places on DATA during the second INTA, and hands it to the core.
// - When the core finishes the handler, it writes the End-Of-Interrupt OCW2 back to the PIC.
// - Sits between the PIC DATA/MODE bus and the CPU core interrupt logic.

---
 rtl/pic_pkg.sv | 38 +++
 rtl/pic_inta_initiator.sv | 154 +++++++++++++++
 tb/tb_pic_inta_initiator.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: definitions shared between the PIC and its CPU-side acknowledge
// initiator.
//   - pic_state_t : states of the INTA initiator sequencer
//   - OCW2_*      : OCW2 command codes in DATA[7:5], as decoded by the PIC
//   - MODE_*      : MODE bus codes shared with the PIC
//   - eoi_byte()  : builds the End-Of-Interrupt OCW2 byte
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INTA1   = 3'd1,
    GAP     = 3'd2,
    INTA2   = 3'd3,
    DELIVER = 3'd4,
    SERVICE = 3'd5,
    EOI     = 3'd6
  } pic_state_t;

  localparam logic [2:0] OCW2_NS_EOI = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI = 3'b011;

  // MODE bus encodings; the PIC decodes the same values.
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_ICW    = 2'b01;
  localparam logic [1:0] MODE_OCW    = 2'b10;
  localparam logic [1:0] MODE_POLL   = 2'b11;

  // Specific EOI names the serviced level (vector[2:0]); non-specific EOI
  // lets the PIC clear its highest in-service bit.
  function automatic logic [7:0] eoi_byte(input logic specific,
                                          input logic [2:0] level);
    if (specific)
      return {OCW2_SP_EOI, 2'b00, level};
    else
      return {OCW2_NS_EOI, 5'b00000};
  endfunction

endpackage

// File: rtl/pic_inta_initiator.sv
// pic_inta_initiator: CPU-side end of the PIC interrupt acknowledge protocol.
// On INT & INT_EN it issues two INTA_N pulses, captures the vector byte the
// PIC drives during the second pulse, hands it to the core, and after the
// handler completes writes the EOI OCW2 back to the PIC.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   asynchronous reset, active-high
//   INT          in   interrupt request from the PIC (level)
//   INT_EN       in   CPU interrupt-enable flag
//   DATA_IN      in   [7:0] PIC data bus (vector byte)
//   INTA_N       out  interrupt acknowledge, active-low, registered
//   vector       out  [7:0] captured vector byte
//   vector_valid out  vector is available to the core
//   spurious     out  captured vector is spurious (qualified by vector_valid)
//   vector_ack   in   core has taken the vector
//   service_done in   core has finished the handler
//   OCW2_WR      out  one-cycle write strobe to the PIC
//   OCW2_DATA    out  [7:0] OCW2 byte (qualified by OCW2_WR)
//   busy         out  high in every state except IDLE
module pic_inta_initiator
  import pic_pkg::*;
#(
  parameter int INTA_PULSE_CYCLES = 2,
  parameter int INTA_GAP_CYCLES   = 1,
  parameter int AEOI              = 0,
  parameter int EOI_SPECIFIC      = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INT,
  input  logic       INT_EN,
  input  logic [7:0] DATA_IN,
  output logic       INTA_N,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       spurious,
  input  logic       vector_ack,
  input  logic       service_done,
  output logic       OCW2_WR,
  output logic [7:0] OCW2_DATA,
  output logic       busy
);

  localparam int MAX_PHASE = (INTA_PULSE_CYCLES > INTA_GAP_CYCLES) ?
                             INTA_PULSE_CYCLES : INTA_GAP_CYCLES;
  localparam int CW = $clog2(MAX_PHASE + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(INTA_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(INTA_GAP_CYCLES - 1);

  pic_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inta_n_q;
  logic [7:0]    vector_q;
  logic          spurious_q;
  // INT level sampled at the end of the first pulse; it only becomes the
  // visible spurious flag together with the vector capture.
  logic          spurious_pend;
  logic          sample_int;
  logic          capture_vec;

  // Next-state / phase counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sample_int  = 1'b0;
    capture_vec = 1'b0;
    case (state_q)
      IDLE: begin
        if (INT && INT_EN) begin
          state_d = INTA1;
          cnt_d   = PULSE_LOAD;
        end
      end
      INTA1: begin
        if (cnt_q == '0) begin
          sample_int = 1'b1;
          state_d    = GAP;
          cnt_d      = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = INTA2;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      INTA2: begin
        if (cnt_q == '0) begin
          capture_vec = 1'b1;
          state_d     = DELIVER;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DELIVER: begin
        // A spurious vector has no in-service bit behind it, and auto-EOI
        // mode clears it in the PIC, so neither needs an EOI write.
        if (vector_ack)
          state_d = (spurious_q || (AEOI != 0)) ? IDLE : SERVICE;
      end
      SERVICE: begin
        if (service_done)
          state_d = EOI;
      end
      EOI: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, INTA_N and capture registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      inta_n_q      <= 1'b1;
      vector_q      <= 8'h00;
      spurious_q    <= 1'b0;
      spurious_pend <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Driven from the next state so the pin changes in the same cycle the
      // state does, straight from a flop.
      inta_n_q <= !((state_d == INTA1) || (state_d == INTA2));
      if (sample_int)
        spurious_pend <= ~INT;
      if (capture_vec) begin
        vector_q   <= DATA_IN;
        spurious_q <= spurious_pend;
      end
    end
  end

  assign INTA_N       = inta_n_q;
  assign vector       = vector_q;
  assign spurious     = spurious_q;
  assign vector_valid = (state_q == DELIVER);
  assign busy         = (state_q != IDLE);
  assign OCW2_WR      = (state_q == EOI);
  assign OCW2_DATA    = OCW2_WR ? eoi_byte(EOI_SPECIFIC != 0, vector_q[2:0])
                                : 8'h00;

endmodule

// File: tb/tb_pic_inta_initiator.sv
// Bench for pic_inta_initiator. u0 uses PULSE=2, GAP=1, AEOI=0,
// EOI_SPECIFIC=1; u1 (non-specific EOI) and u2 (auto-EOI) share its inputs.
// Expected vector deliveries and EOI writes of u0 are queued by the stimulus
// and consumed by a monitor when the DUT presents them.
module tb_pic_inta_initiator;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INT = 1'b0;
  logic       INT_EN = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       vector_ack = 1'b0;
  logic       service_done = 1'b0;

  logic       inta_n0, vv0, sp0, wr0, busy0;
  logic [7:0] vec0, od0;
  logic       inta_n1, vv1, sp1, wr1, busy1;
  logic [7:0] vec1, od1;
  logic       inta_n2, vv2, sp2, wr2, busy2;
  logic [7:0] vec2, od2;

  pic_inta_initiator #(.INTA_PULSE_CYCLES(2), .INTA_GAP_CYCLES(1),
                       .AEOI(0), .EOI_SPECIFIC(1)) u0 (
    .CLK(CLK), .RST(RST), .INT(INT), .INT_EN(INT_EN), .DATA_IN(DATA_IN),
    .INTA_N(inta_n0), .vector(vec0), .vector_valid(vv0), .spurious(sp0),
    .vector_ack(vector_ack), .service_done(service_done),
    .OCW2_WR(wr0), .OCW2_DATA(od0), .busy(busy0));

  pic_inta_initiator #(.INTA_PULSE_CYCLES(2), .INTA_GAP_CYCLES(1),
                       .AEOI(0), .EOI_SPECIFIC(0)) u1 (
    .CLK(CLK), .RST(RST), .INT(INT), .INT_EN(INT_EN), .DATA_IN(DATA_IN),
    .INTA_N(inta_n1), .vector(vec1), .vector_valid(vv1), .spurious(sp1),
    .vector_ack(vector_ack), .service_done(service_done),
    .OCW2_WR(wr1), .OCW2_DATA(od1), .busy(busy1));

  pic_inta_initiator #(.INTA_PULSE_CYCLES(2), .INTA_GAP_CYCLES(1),
                       .AEOI(1), .EOI_SPECIFIC(1)) u2 (
    .CLK(CLK), .RST(RST), .INT(INT), .INT_EN(INT_EN), .DATA_IN(DATA_IN),
    .INTA_N(inta_n2), .vector(vec2), .vector_valid(vv2), .spurious(sp2),
    .vector_ack(vector_ack), .service_done(service_done),
    .OCW2_WR(wr2), .OCW2_DATA(od2), .busy(busy2));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_eoi;
    logic [7:0] data;
    logic       sp;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  int   eoi0 = 0;
  int   eoi1 = 0;
  int   eoi2 = 0;
  logic prev_vv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: consumes expectations when u0 presents a vector or an EOI write.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (vv0 && !prev_vv) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got %0h expected none", vec0);
      end else begin
        e = expq.pop_front();
        chk("vec_kind", 32'(e.is_eoi), 32'd0);
        chk("vector", 32'(vec0), 32'(e.data));
        chk("spurious", 32'(sp0), 32'(e.sp));
        chk("vec_cycle", cyc, e.cyc);
      end
    end
    prev_vv <= vv0;
    if (wr0) begin
      eoi0++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_eoi: got %0h expected none", od0);
      end else begin
        e = expq.pop_front();
        chk("eoi_kind", 32'(e.is_eoi), 32'd1);
        chk("eoi_data", 32'(od0), 32'(e.data));
        chk("eoi_cycle", cyc, e.cyc);
      end
    end
    if (wr1) begin
      eoi1++;
      chk("ns_eoi_data", 32'(od1), 32'h20);
    end
    if (wr2) eoi2++;
  end

  // Starts a sequence at the current negedge (cycle 0) and checks the INTA_N
  // waveform for cycles 1..6. INT is dropped after the check of cycle drop_k
  // (0 = keep it high).
  task automatic ack_seq(input logic [7:0] d, input bit spur, input int drop_k);
    int t0;
    logic [6:1] pat;
    pat = 6'b100100;
    INT = 1'b1;
    INT_EN = 1'b1;
    DATA_IN = d;
    t0 = cyc;
    expq.push_back('{1'b0, d, spur, t0 + 6});
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      chk("inta_n_wave", 32'(inta_n0), 32'(pat[k]));
      if (k == drop_k) INT = 1'b0;
    end
    chk("vector_valid", 32'(vv0), 32'd1);
  endtask

  // Acks the vector, completes the handler, and queues the expected EOI.
  task automatic finish_eoi(input logic [7:0] eoi, input bit chk_aeoi,
                            input bit both);
    vector_ack = 1'b1;
    service_done = both;
    @(negedge CLK);
    vector_ack = 1'b0;
    service_done = 1'b0;
    chk("vv_after_ack", 32'(vv0), 32'd0);
    chk("busy_service", 32'(busy0), 32'd1);
    if (chk_aeoi) chk("aeoi_busy", 32'(busy2), 32'd0);
    if (both) begin
      repeat (3) begin
        @(negedge CLK);
        chk("no_eoi_wo_done", 32'(wr0), 32'd0);
      end
    end
    @(negedge CLK);
    chk("no_early_eoi", 32'(wr0), 32'd0);
    service_done = 1'b1;
    expq.push_back('{1'b1, eoi, 1'b0, cyc + 1});
    @(negedge CLK);
    service_done = 1'b0;
    @(negedge CLK);
    chk("busy_idle", 32'(busy0), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_inta_n", 32'(inta_n0), 32'd1);
    chk("rst_vector", 32'(vec0), 32'd0);
    chk("rst_vv", 32'(vv0), 32'd0);
    chk("rst_spurious", 32'(sp0), 32'd0);
    chk("rst_wr", 32'(wr0), 32'd0);
    chk("rst_ocw2", 32'(od0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Normal acknowledge, specific EOI 0x63 (non-specific 0x20 on u1)
    ack_seq(8'h0B, 1'b0, 3);
    finish_eoi(8'h63, 1'b1, 1'b0);

    // Spurious request: INT gone before the end of the first pulse
    ack_seq(8'h0F, 1'b1, 1);
    vector_ack = 1'b1;
    @(negedge CLK);
    vector_ack = 1'b0;
    chk("spur_busy", 32'(busy0), 32'd0);
    chk("spur_hold", 32'(sp0), 32'd1);
    chk("vec_hold", 32'(vec0), 32'h0F);
    repeat (4) @(negedge CLK);

    // Interrupts disabled
    INT = 1'b1;
    INT_EN = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      chk("dis_inta_n", 32'(inta_n0), 32'd1);
      chk("dis_busy", 32'(busy0), 32'd0);
    end
    ack_seq(8'h1C, 1'b0, 3);
    finish_eoi(8'h64, 1'b0, 1'b0);

    // Reset during INTA2
    INT = 1'b1;
    INT_EN = 1'b1;
    DATA_IN = 8'h55;
    repeat (4) @(negedge CLK);
    chk("inta2_low", 32'(inta_n0), 32'd0);
    chk("inta2_busy", 32'(busy0), 32'd1);
    RST = 1'b1;
    #1;
    chk("arst_inta_n", 32'(inta_n0), 32'd1);
    chk("arst_vv", 32'(vv0), 32'd0);
    chk("arst_spurious", 32'(sp0), 32'd0);
    chk("arst_vector", 32'(vec0), 32'd0);
    chk("arst_wr", 32'(wr0), 32'd0);
    chk("arst_ocw2", 32'(od0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    @(negedge CLK);
    chk("rst_hold_inta_n", 32'(inta_n0), 32'd1);
    chk("rst_hold_wr", 32'(wr0), 32'd0);
    RST = 1'b0;
    ack_seq(8'h2A, 1'b0, 3);
    finish_eoi(8'h62, 1'b0, 1'b0);

    // vector_ack and service_done together: done must be re-asserted
    ack_seq(8'h05, 1'b0, 3);
    finish_eoi(8'h65, 1'b0, 1'b1);

    // INT held through EOI: next sequence starts right after IDLE
    ack_seq(8'h07, 1'b0, 0);
    finish_eoi(8'h67, 1'b0, 1'b0);
    chk("b2b_idle_inta_n", 32'(inta_n0), 32'd1);
    ack_seq(8'h01, 1'b0, 3);
    finish_eoi(8'h61, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    chk("u1_eoi_count", eoi1, eoi0);
    chk("aeoi_eoi_count", eoi2, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
